// File: rtl/sevenseg_pkg.sv
// Shared seven-segment definitions: hex glyph table, segment bit order,
// scan FSM states and the active-level helper.
package sevenseg_pkg;

    typedef enum logic {
        ST_BLANK,
        ST_DISPLAY
    } scan_state_e;

    // Position of each segment inside seg[6:0]
    localparam int unsigned SEG_A_BIT = 6;
    localparam int unsigned SEG_B_BIT = 5;
    localparam int unsigned SEG_C_BIT = 4;
    localparam int unsigned SEG_D_BIT = 3;
    localparam int unsigned SEG_E_BIT = 2;
    localparam int unsigned SEG_F_BIT = 1;
    localparam int unsigned SEG_G_BIT = 0;

    localparam logic [6:0] SEG_0 = 7'h7E;
    localparam logic [6:0] SEG_1 = 7'h30;
    localparam logic [6:0] SEG_2 = 7'h6D;
    localparam logic [6:0] SEG_3 = 7'h79;
    localparam logic [6:0] SEG_4 = 7'h33;
    localparam logic [6:0] SEG_5 = 7'h5B;
    localparam logic [6:0] SEG_6 = 7'h5F;
    localparam logic [6:0] SEG_7 = 7'h70;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h7B;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h1F;
    localparam logic [6:0] SEG_C = 7'h4E;
    localparam logic [6:0] SEG_D = 7'h3D;
    localparam logic [6:0] SEG_E = 7'h4F;
    localparam logic [6:0] SEG_F = 7'h47;

    // Convert an active-high segment pattern to the board's drive level
    function automatic logic [6:0] seg_level(input logic [6:0] lit, input logic active_low);
        return active_low ? ~lit : lit;
    endfunction

endpackage

// File: rtl/sevenseg_scan_if.sv
// Display data and drive bundle between the controlling logic (master)
// and the scan driver (slave).
interface sevenseg_scan_if #(
    parameter int unsigned N_DIGITS = 4
);
    logic [4*N_DIGITS-1:0] value;
    logic [N_DIGITS-1:0]   dp_in;
    logic                  load;
    logic                  lz_en;
    logic [6:0]            seg;
    logic                  dp;
    logic [N_DIGITS-1:0]   dig_en;
    logic                  frame_start;

    modport master (
        output value, dp_in, load, lz_en,
        input  seg, dp, dig_en, frame_start
    );

    modport slave (
        input  value, dp_in, load, lz_en,
        output seg, dp, dig_en, frame_start
    );
endinterface

// File: rtl/sevenseg_hex_dec.sv
// Combinational 4-bit to seven-segment decoder, active-high output.
module sevenseg_hex_dec
    import sevenseg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    logic [6:0] lit;

    always_comb begin
        lit = '0;
        case (nibble)
            4'h0: lit = SEG_0;
            4'h1: lit = SEG_1;
            4'h2: lit = SEG_2;
            4'h3: lit = SEG_3;
            4'h4: lit = SEG_4;
            4'h5: lit = SEG_5;
            4'h6: lit = SEG_6;
            4'h7: lit = SEG_7;
            4'h8: lit = SEG_8;
            4'h9: lit = SEG_9;
            4'hA: lit = SEG_A;
            4'hB: lit = SEG_B;
            4'hC: lit = SEG_C;
            4'hD: lit = SEG_D;
            4'hE: lit = SEG_E;
            4'hF: lit = SEG_F;
            default: lit = '0;
        endcase
        seg = {lit[SEG_A_BIT], lit[SEG_B_BIT], lit[SEG_C_BIT], lit[SEG_D_BIT],
               lit[SEG_E_BIT], lit[SEG_F_BIT], lit[SEG_G_BIT]};
    end
endmodule

// File: rtl/sevenseg_scan.sv
// Time-multiplexed N-digit seven-segment driver with blank interval,
// tear-free double-buffered data and optional leading-zero suppression.
module sevenseg_scan
    import sevenseg_pkg::*;
#(
    parameter int unsigned N_DIGITS       = 4,
    parameter int unsigned CLK_DIV        = 50000,
    parameter int unsigned BLANK_CYCLES   = 500,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
    input logic             clk,
    input logic             rst_n,
    sevenseg_scan_if.slave  bus
);
    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] DIG_OFF  = DIG_ACTIVE_LOW ? '1 : '0;

    logic [CNT_W-1:0]      cnt, cnt_next;
    logic [IDX_W-1:0]      idx;
    scan_state_e           state;
    logic [4*N_DIGITS-1:0] act_val, pend_val;
    logic [N_DIGITS-1:0]   act_dp, pend_dp;
    logic                  pend_valid;
    logic                  frame_wrap;
    logic [3:0]            nibble;
    logic [6:0]            dec_seg, seg_lit;
    logic [N_DIGITS-1:0]   lz_blank, sel;
    logic                  zero_above;

    sevenseg_hex_dec u_dec (
        .nibble (nibble),
        .seg    (dec_seg)
    );

    always_comb begin
        cnt_next   = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        frame_wrap = (cnt == CNT_LAST) && (idx == IDX_LAST);
        nibble     = act_val[4*idx +: 4];
        sel        = '0;
        sel[idx]   = 1'b1;
        // Walk from the top digit down; a digit is blank while everything at or above it is zero
        zero_above = 1'b1;
        lz_blank   = '0;
        for (int unsigned k = 0; k < N_DIGITS; k++) begin
            zero_above = zero_above & (act_val[4*(N_DIGITS-1-k) +: 4] == 4'h0);
            lz_blank[N_DIGITS-1-k] = zero_above && (k != N_DIGITS - 1);
        end
        seg_lit = (bus.lz_en && lz_blank[idx]) ? '0 : dec_seg;
    end

    // state tracks the slot region of cnt; outputs are registered from it, one cycle behind
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt             <= '0;
            idx             <= '0;
            state           <= ST_BLANK;
            bus.seg         <= seg_level(7'h00, SEG_ACTIVE_LOW);
            bus.dp          <= SEG_ACTIVE_LOW;
            bus.dig_en      <= DIG_OFF;
            bus.frame_start <= 1'b0;
        end else begin
            cnt <= cnt_next;
            if (cnt == CNT_LAST) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end
            state           <= (32'(cnt_next) < BLANK_CYCLES) ? ST_BLANK : ST_DISPLAY;
            bus.frame_start <= (cnt == '0) && (idx == '0);
            case (state)
                ST_DISPLAY: begin
                    bus.dig_en <= sel ^ DIG_OFF;
                    bus.seg    <= seg_level(seg_lit, SEG_ACTIVE_LOW);
                    bus.dp     <= act_dp[idx] ^ SEG_ACTIVE_LOW;
                end
                default: begin
                    bus.dig_en <= DIG_OFF;
                    bus.seg    <= seg_level(7'h00, SEG_ACTIVE_LOW);
                    bus.dp     <= SEG_ACTIVE_LOW;
                end
            endcase
        end
    end

    // A load coinciding with the frame boundary lands in pending after the old pending moves out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_val    <= '0;
            act_dp     <= '0;
            pend_val   <= '0;
            pend_dp    <= '0;
            pend_valid <= 1'b0;
        end else begin
            if (frame_wrap && pend_valid) begin
                act_val <= pend_val;
                act_dp  <= pend_dp;
            end
            if (bus.load) begin
                pend_val   <= bus.value;
                pend_dp    <= bus.dp_in;
                pend_valid <= 1'b1;
            end else if (frame_wrap) begin
                pend_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sevenseg_scan.sv
// Scoreboard bench for sevenseg_scan: N_DIGITS=4, CLK_DIV=8, BLANK_CYCLES=2, active-low drive.
module tb_sevenseg_scan;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    sevenseg_scan_if #(.N_DIGITS(4)) bus ();

    sevenseg_scan #(
        .N_DIGITS       (4),
        .CLK_DIV        (8),
        .BLANK_CYCLES   (2),
        .SEG_ACTIVE_LOW (1'b1),
        .DIG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [3:0] dig;
        logic [6:0] seg;
        logic       dp;
        logic       fs;
    } obs_t;

    obs_t        exp_q[$];
    int          tag_q[$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [3:0]  dig_sel [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

    task automatic check(input string name, input obs_t exp);
        obs_t got;
        got = {bus.dig_en, bus.seg, bus.dp, bus.frame_start};
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got dig_en=%h seg=%h dp=%b fs=%b, need dig_en=%h seg=%h dp=%b fs=%b",
                     name, got.dig, got.seg, got.dp, got.fs, exp.dig, exp.seg, exp.dp, exp.fs);
        end
    endtask

    // Monitor: one expected record per scanned clock, sampled on the falling edge
    always @(negedge clk) begin
        if (rst_n && exp_q.size() > 0) begin
            obs_t e;
            int   t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check($sformatf("scan_f%0d_p%0d", t / 100, t % 100), e);
        end
    end

    // Plays n cycles of a frame; s0..s3/dpx are the hand-derived digit codes on display,
    // la/lb are frame cycles (-1 = none) at which a load is issued.
    task automatic play(input int fr, input int n,
                        input logic [6:0] s0, input logic [6:0] s1,
                        input logic [6:0] s2, input logic [6:0] s3,
                        input logic [3:0] dpx,
                        input int la, input logic [15:0] va, input logic [3:0] da,
                        input int lb, input logic [15:0] vb, input logic [3:0] db);
        logic [6:0] sg [4];
        sg = '{s0, s1, s2, s3};
        for (int p = 0; p < n; p++) begin
            obs_t e;
            int   d;
            int   c;
            d = p / 8;
            c = p % 8;
            if (p == la) begin
                bus.value = va; bus.dp_in = da; bus.load = 1'b1;
            end else if (p == lb) begin
                bus.value = vb; bus.dp_in = db; bus.load = 1'b1;
            end
            if (c < 2) begin
                e.dig = 4'hF; e.seg = 7'h7F; e.dp = 1'b1; e.fs = (p == 0);
            end else begin
                e.dig = dig_sel[d]; e.seg = sg[d]; e.dp = ~dpx[d]; e.fs = 1'b0;
            end
            exp_q.push_back(e);
            tag_q.push_back(fr * 100 + p);
            @(posedge clk);
            #1;
            bus.load = 1'b0;
        end
    endtask

    initial begin
        obs_t off;
        off.dig = 4'hF; off.seg = 7'h7F; off.dp = 1'b1; off.fs = 1'b0;
        bus.value = '0;
        bus.dp_in = '0;
        bus.load  = 1'b0;
        bus.lz_en = 1'b0;

        repeat (3) @(posedge clk);
        #2;
        check("reset_idle", off);
        @(negedge clk);
        #1 rst_n = 1'b1;

        play(0, 32, 7'h01, 7'h01, 7'h01, 7'h01, 4'h0, 3, 16'h1234, 4'h0, -1, 16'h0, 4'h0);
        play(1, 32, 7'h4C, 7'h06, 7'h12, 7'h4F, 4'h0, 20, 16'hFEDC, 4'h0, -1, 16'h0, 4'h0);
        play(2, 32, 7'h31, 7'h42, 7'h30, 7'h38, 4'h0, 7, 16'hBA98, 4'h0, -1, 16'h0, 4'h0);
        play(3, 32, 7'h00, 7'h04, 7'h08, 7'h60, 4'h0, 28, 16'h7654, 4'h0, -1, 16'h0, 4'h0);
        play(4, 32, 7'h4C, 7'h24, 7'h20, 7'h0F, 4'h0, 10, 16'h0050, 4'h0, -1, 16'h0, 4'h0);
        bus.lz_en = 1'b1;
        play(5, 32, 7'h01, 7'h24, 7'h7F, 7'h7F, 4'h0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
        bus.lz_en = 1'b0;
        play(6, 32, 7'h01, 7'h24, 7'h01, 7'h01, 4'h0, 13, 16'h1111, 4'h0, -1, 16'h0, 4'h0);
        play(7, 32, 7'h4F, 7'h4F, 7'h4F, 7'h4F, 4'h0, 4, 16'h2222, 4'h0, 20, 16'h3333, 4'h0);
        play(8, 32, 7'h06, 7'h06, 7'h06, 7'h06, 4'h0, 20, 16'h5555, 4'h0, 31, 16'h4444, 4'b0100);
        play(9, 32, 7'h24, 7'h24, 7'h24, 7'h24, 4'h0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
        play(10, 32, 7'h4C, 7'h4C, 7'h4C, 7'h4C, 4'b0100, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
        play(11, 4, 7'h4C, 7'h4C, 7'h4C, 7'h4C, 4'b0100, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

        // Outputs are mid-DISPLAY here; reset must blank them without a clock edge
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("reset_mid_display", off);
        @(negedge clk);
        #1 rst_n = 1'b1;
        play(12, 32, 7'h01, 7'h01, 7'h01, 7'h01, 4'h0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: got %0d pending records, need 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got no finish by 50000ns, need finish");
        $fatal(1, "watchdog expired");
    end
endmodule
